// File: rtl/i2c_target_pkg.sv
// Shared types and bus-level constants for the I2C register target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_PTR,
    ST_ACK_PTR,
    ST_WDATA,
    ST_ACK_WDATA,
    ST_RDATA,
    ST_ACK_RDATA,
    ST_IGNORE
  } state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic ACK          = 1'b0;

endpackage

// File: rtl/i2c_in_filter.sv
// Pin conditioner: 2-flop synchroniser plus FILT_LEN-sample glitch filter, with edge pulses.
// Level and rise/fall pulses update together, FILT_LEN+2 clocks after a clean pin change; no backpressure.
module i2c_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_USB,
  input  logic rst,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // The counter only runs while the synchronised pin disagrees with the accepted level.
  always_comb begin
    cnt_d  = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        lvl_d  = sync_q[1];
        rise_d = sync_q[1];
        fall_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_USB or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target loading byte registers; `I2C_TARGET_READ_EN adds register read-back.
// Write strobe one clk after the filtered 8th SCL rise; never stretches SCL, SDA is open-drain only.
module i2c_reg_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h52,
  parameter int         NREGS    = 4,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk_USB,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       stop_pulse
);

  localparam logic [7:0] NREGS_B = 8'(NREGS);
`ifdef I2C_TARGET_READ_EN
  localparam logic RD_EN = 1'b1;
`else
  localparam logic RD_EN = 1'b0;
`endif

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_USB (clk_USB),
    .rst     (rst),
    .pin_i   (scl_i),
    .lvl_o   (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_USB (clk_USB),
    .rst     (rst),
    .pin_i   (sda_i),
    .lvl_o   (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wr_en_q, wr_en_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       stop_q, stop_d;
  logic       armed_q, armed_d;
`ifdef I2C_TARGET_READ_EN
  logic       mack_q, mack_d;
`else
  logic       unused_rdata;
  assign unused_rdata = ^reg_rdata;
`endif

  logic       start_cond, stop_cond, rx_state, bit_fall, byte_end, addr_ack;
  logic [7:0] rx_byte;

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign rx_state   = (state_q == ST_ADDR) || (state_q == ST_PTR) || (state_q == ST_WDATA);
  // The SCL fall that completes a START is not a data bit; armed_q skips it.
  assign bit_fall   = scl_fall & armed_q;
  assign byte_end   = bit_fall & (bit_cnt_q == 3'd7);
  assign rx_byte    = {shift_q[6:0], sda_lvl};
  assign addr_ack   = (shift_q[7:1] == DEV_ADDR) &&
                      ((shift_q[0] == I2C_RW_WRITE) || ((shift_q[0] == I2C_RW_READ) && RD_EN));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_en_d   = 1'b0;
    oe_d      = oe_q;
    busy_d    = busy_q;
    stop_d    = 1'b0;
    armed_d   = armed_q | scl_rise;
`ifdef I2C_TARGET_READ_EN
    mack_d    = mack_q;
`endif

    if (stop_cond) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
    end else if (start_cond) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      busy_d    = 1'b1;
      armed_d   = 1'b0;
    end else begin
      if (rx_state && scl_rise) begin
        shift_d = rx_byte;
      end
      if (rx_state && bit_fall) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end

      case (state_q)
        ST_ADDR: begin
          if (byte_end) begin
            if (addr_ack) begin
              oe_d    = ~ACK;
              state_d = ST_ACK_ADDR;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_ACK_ADDR: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            state_d   = ST_PTR;
`ifdef I2C_TARGET_READ_EN
            if (shift_q[0] == I2C_RW_READ) begin
              shift_d = reg_rdata;
              oe_d    = ~reg_rdata[7];
              state_d = ST_RDATA;
            end
`endif
          end
        end
        ST_PTR: begin
          if (byte_end) begin
            if (shift_q < NREGS_B) begin
              addr_d  = shift_q;
              oe_d    = ~ACK;
              state_d = ST_ACK_PTR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ACK_PTR: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            state_d   = ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (scl_rise && (bit_cnt_q == 3'd7) && (addr_q < NREGS_B)) begin
            wr_en_d = 1'b1;
            wdata_d = rx_byte;
          end
          if (byte_end) begin
            if (addr_q < NREGS_B) begin
              oe_d    = ~ACK;
              state_d = ST_ACK_WDATA;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ACK_WDATA: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            addr_d    = addr_q + 8'd1;
            state_d   = ST_WDATA;
          end
        end
`ifdef I2C_TARGET_READ_EN
        ST_RDATA: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              oe_d    = 1'b0;
              state_d = ST_ACK_RDATA;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        ST_ACK_RDATA: begin
          // Pointer advances at the ACK sample so reg_rdata is already valid by the reload fall.
          if (scl_rise) begin
            mack_d = (sda_lvl == ACK);
            if (sda_lvl == ACK) begin
              addr_d = addr_q + 8'd1;
            end
          end
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (mack_q) begin
              shift_d = reg_rdata;
              oe_d    = ~reg_rdata[7];
              state_d = ST_RDATA;
            end else begin
              oe_d    = 1'b0;
              state_d = ST_IGNORE;
            end
          end
        end
`endif
        ST_IDLE, ST_IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_USB or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      stop_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_en_q   <= wr_en_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      stop_q    <= stop_d;
      armed_q   <= armed_d;
    end
  end

`ifdef I2C_TARGET_READ_EN
  always_ff @(posedge clk_USB or posedge rst) begin
    if (rst) begin
      mack_q <= 1'b0;
    end else begin
      mack_q <= mack_d;
    end
  end
`endif

  assign sda_oe     = oe_q;
  assign reg_wr_en  = wr_en_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign busy       = busy_q;
  assign stop_pulse = stop_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged 500 kHz master, transaction-level model, strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_reg_target;

  localparam int Q     = 500;
  localparam int NREGS = 4;

  logic       clk_USB = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl_low = 1'b0;
  logic       m_sda_low = 1'b0;
  logic       scl_i, sda_i;
  logic       sda_oe, reg_wr_en, busy, stop_pulse;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  // Wired-AND lines with pull-ups.
  assign scl_i = ~m_scl_low;
  assign sda_i = ~(m_sda_low | sda_oe);

  always #42 clk_USB = ~clk_USB;

  function automatic logic [7:0] rd_val(input logic [7:0] a);
    return (a * 8'd37) ^ 8'h5C;
  endfunction
  assign reg_rdata = rd_val(reg_addr);

  i2c_reg_target dut (
    .clk_USB    (clk_USB),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_oe     (sda_oe),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .stop_pulse (stop_pulse)
  );

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   stop_cnt = 0;
  int   exp_stops = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic wr_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write strobe.
  always @(negedge clk_USB) begin
    if (stop_pulse) stop_cnt++;
    if (reg_wr_en) begin
      check("strobe_width", {31'd0, wr_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h, expected none", reg_addr, reg_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_addr", {24'd0, reg_addr}, {24'd0, mon_e.a});
        check("strobe_data", {24'd0, reg_wdata}, {24'd0, mon_e.d});
      end
    end
    wr_prev = reg_wr_en;
  end

  task automatic i2c_start();
    m_sda_low = 1'b0; #Q;
    m_scl_low = 1'b0; #Q;
    m_sda_low = 1'b1; #Q;
    m_scl_low = 1'b1; #Q;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #Q;
    m_scl_low = 1'b0; #Q;
    m_sda_low = 1'b0; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; #Q;
    m_scl_low = 1'b0; #(2*Q);
    m_scl_low = 1'b1; #Q;
  endtask

  task automatic ack_clock(output logic ack, output logic bsy);
    m_sda_low = 1'b0; #Q;
    m_scl_low = 1'b0; #Q;
    ack = sda_i;
    bsy = busy; #Q;
    m_scl_low = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack, output logic bsy);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_clock(ack, bsy);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] v);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q; m_scl_low = 1'b0;
      #Q; v[i] = sda_i;
      #Q; m_scl_low = 1'b1;
      #Q;
    end
    m_sda_low = mack; #Q;
    m_scl_low = 1'b0; #(2*Q);
    m_scl_low = 1'b1; #Q;
    m_sda_low = 1'b0;
  endtask

  task automatic finish_stop(input string tag);
    i2c_stop();
    exp_stops++;
    #200;
    check({tag, "_stops"}, stop_cnt, exp_stops);
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  // Reference: byte 0 must be our write address, byte 1 an in-range pointer, then
  // data bytes fill consecutive registers until the pointer leaves the bank.
  // Anything rejected is NACKed along with every later byte of the transfer.
  task automatic run_write(input string tag, input int n, input logic [47:0] v, input bit do_stop);
    logic [7:0] b;
    logic       ack, bsy;
    bit         ok;
    int         ptr;
    ok  = 1'b1;
    ptr = 0;
    i2c_start();
    for (int i = 0; i < n; i++) begin
      b = v[8*(n-1-i) +: 8];
      if (i == 0) begin
        ok = (b == 8'hA4);
      end else if (i == 1) begin
        ok  = ok && (int'(b) < NREGS);
        ptr = int'(b);
      end else begin
        ok = ok && (ptr < NREGS);
        if (ok) begin
          exp_q.push_back({8'(ptr), b});
          ptr++;
        end
      end
      write_byte(b, ack, bsy);
      check($sformatf("%s_ack%0d", tag, i), {31'd0, ack}, ok ? 32'd0 : 32'd1);
      if (i == 0) check($sformatf("%s_busy", tag), {31'd0, bsy}, {31'd0, ok});
    end
    if (do_stop) finish_stop(tag);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, bsy;
    logic [7:0] rv;
    logic [47:0] v;
    int          nd;
    logic [7:0]  a;

    #300;
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    check("rst_addr", {24'd0, reg_addr}, 32'd0);
    check("rst_wdata", {24'd0, reg_wdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stop", {31'd0, stop_pulse}, 32'd0);
    rst = 1'b0;
    #1000;

    run_write("t1", 3, {8'hA4, 8'h00, 8'h44}, 1'b1);
    run_write("t2", 2, {8'hA6, 8'h00}, 1'b1);
    run_write("t3", 4, {8'hA4, 8'h01, 8'h13, 8'h00}, 1'b1);
    run_write("t4", 3, {8'hA4, 8'h04, 8'h55}, 1'b1);
    run_write("t5", 4, {8'hA4, 8'h03, 8'h7E, 8'h7F}, 1'b1);
    run_write("t6a", 2, {8'hA4, 8'h02}, 1'b0);
    run_write("t6b", 3, {8'hA4, 8'h00, 8'h9A}, 1'b1);

`ifdef I2C_TARGET_READ_EN
    run_write("rd_set", 2, {8'hA4, 8'h02}, 1'b0);
    i2c_start();
    write_byte(8'hA5, ack, bsy);
    check("rd_addr_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b1, rv);
    check("rd_byte0", {24'd0, rv}, {24'd0, rd_val(8'd2)});
    read_byte(1'b0, rv);
    check("rd_byte1", {24'd0, rv}, {24'd0, rd_val(8'd3)});
    finish_stop("rd");
`else
    run_write("rd_nack", 2, {8'hA5, 8'h00}, 1'b1);
`endif

    // Reset while the target is driving the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(8'hA4 >> i);
    m_sda_low = 1'b0; #Q;
    m_scl_low = 1'b0; #Q;
    check("ack_before_rst", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    #200;
    rst = 1'b0;
    #(Q - 201);
    m_scl_low = 1'b1; #Q;
    finish_stop("rst_ack");

    // Reset in the middle of a data byte: partial byte must be dropped.
    run_write("rst_mid", 2, {8'hA4, 8'h00}, 1'b0);
    for (int i = 7; i >= 4; i--) send_bit(8'hF0 >> i);
    rst = 1'b1;
    #1;
    check("rst_mid_sda_oe", {31'd0, sda_oe}, 32'd0);
    #200;
    rst = 1'b0;
    for (int i = 3; i >= 0; i--) send_bit(8'hF0 >> i);
    ack_clock(ack, bsy);
    check("rst_mid_nack", {31'd0, ack}, 32'd1);
    check("rst_mid_addr", {24'd0, reg_addr}, 32'd0);
    finish_stop("rst_mid");
    run_write("recover", 3, {8'hA4, 8'h01, 8'h5A}, 1'b1);

    for (int t = 0; t < 16; t++) begin
      nd = $urandom_range(0, 3);
      a  = ($urandom_range(0, 9) < 7) ? 8'hA4 : (8'($urandom) & 8'hFE);
      v  = '0;
      v  = {v[39:0], a};
      v  = {v[39:0], 8'($urandom_range(0, 5))};
      for (int k = 0; k < nd; k++) v = {v[39:0], 8'($urandom)};
      run_write($sformatf("rnd%0d", t), 2 + nd, v, 1'b1);
    end

    #1000;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
